// File: rtl/nap_controller_if.sv
// Link between the nap controller and the BCD countdown-step datapath:
// the controller presents the current value plus a start strobe, the datapath answers with digits and a done flag.
interface nap_controller_if;
  logic       tmrStart;
  logic [3:0] tmrSetHour10, tmrSetHour1, tmrSetMinute10, tmrSetMinute1, tmrSetSecond10, tmrSetSecond1;
  logic [3:0] tmrGetHour10, tmrGetHour1, tmrGetMinute10, tmrGetMinute1, tmrGetSecond10, tmrGetSecond1;
  logic       tmrComplete;

  modport master (
    output tmrStart,
    output tmrSetHour10, tmrSetHour1, tmrSetMinute10, tmrSetMinute1, tmrSetSecond10, tmrSetSecond1,
    input  tmrGetHour10, tmrGetHour1, tmrGetMinute10, tmrGetMinute1, tmrGetSecond10, tmrGetSecond1,
    input  tmrComplete
  );

  modport slave (
    input  tmrStart,
    input  tmrSetHour10, tmrSetHour1, tmrSetMinute10, tmrSetMinute1, tmrSetSecond10, tmrSetSecond1,
    output tmrGetHour10, tmrGetHour1, tmrGetMinute10, tmrGetMinute1, tmrGetSecond10, tmrGetSecond1,
    output tmrComplete
  );
endinterface

// File: rtl/nap_controller.sv
// Power-nap sequencer: owns the HH:MM:SS count, generates the 1-second tick, drives one
// datapath step per tick, merges the returned digits and raises the alarm at zero.
module nap_controller #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned STEP_WAIT     = 4,
  parameter int unsigned ALARM_SECONDS = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [3:0]       setHour10,
  input  logic [3:0]       setHour1,
  input  logic [3:0]       setMinute10,
  input  logic [3:0]       setMinute1,
  input  logic [3:0]       setSecond10,
  input  logic [3:0]       setSecond1,
  input  logic             btnStart,
  input  logic             btnPause,
  input  logic             btnCancel,
  nap_controller_if.master tmr,
  output logic [3:0]       dispHour10,
  output logic [3:0]       dispHour1,
  output logic [3:0]       dispMinute10,
  output logic [3:0]       dispMinute1,
  output logic [3:0]       dispSecond10,
  output logic [3:0]       dispSecond1,
  output logic             running,
  output logic             alarm,
  output logic             loadErr,
  output logic             stepErr
);
  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned SW = $clog2(STEP_WAIT + 1);
  localparam int unsigned AW = (ALARM_SECONDS > 1) ? $clog2(ALARM_SECONDS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_WAIT);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECONDS - 1);

  typedef enum logic [2:0] {IDLE, ARMED, RUN, STEP, PAUSE, ALARM} state_t;

  state_t          state;
  // Digit index 0 is Second1, 5 is Hour10.
  logic [5:0][3:0] cur;
  logic [5:0][3:0] set_val;
  logic [5:0][3:0] get_val;
  logic [5:0][3:0] merged;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   step_cnt;
  logic [AW-1:0]   alarm_cnt;
  logic            pause_pend;
  logic            tick;
  logic            load_ok;
  logic            set_zero;
  logic            cur_zero;
  logic            lower_zero;

  assign set_val = {setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1};
  assign get_val = {tmr.tmrGetHour10, tmr.tmrGetHour1, tmr.tmrGetMinute10,
                    tmr.tmrGetMinute1, tmr.tmrGetSecond10, tmr.tmrGetSecond1};

  assign {tmr.tmrSetHour10, tmr.tmrSetHour1, tmr.tmrSetMinute10,
          tmr.tmrSetMinute1, tmr.tmrSetSecond10, tmr.tmrSetSecond1} = cur;
  assign {dispHour10, dispHour1, dispMinute10, dispMinute1, dispSecond10, dispSecond1} = cur;

  assign tick     = (tick_cnt == TICK_LAST);
  assign set_zero = (set_val == '0);
  assign cur_zero = (cur == '0);

  // Datapath digits are taken up to and including the lowest non-zero digit; higher ones are kept.
  always_comb begin
    lower_zero = 1'b1;
    merged     = cur;
    load_ok    = (set_val[1] <= 4'd5) && (set_val[3] <= 4'd5);
    for (int unsigned i = 0; i < 6; i++) begin
      if (set_val[i] > 4'd9) load_ok = 1'b0;
      if (lower_zero) merged[i] = get_val[i];
      if (cur[i] != 4'd0) lower_zero = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || btnCancel) begin
      state        <= IDLE;
      cur          <= '0;
      tick_cnt     <= '0;
      step_cnt     <= '0;
      alarm_cnt    <= '0;
      pause_pend   <= 1'b0;
      tmr.tmrStart <= 1'b0;
      running      <= 1'b0;
      alarm        <= 1'b0;
      loadErr      <= 1'b0;
      stepErr      <= 1'b0;
    end else begin
      tmr.tmrStart <= 1'b0;
      loadErr      <= 1'b0;
      unique case (state)
        IDLE, ARMED: begin
          if (load) begin
            if (!load_ok) begin
              loadErr <= 1'b1;
            end else begin
              cur     <= set_val;
              stepErr <= 1'b0;
              state   <= set_zero ? IDLE : ARMED;
            end
          end else if (state == ARMED && btnStart) begin
            state    <= RUN;
            running  <= 1'b1;
            tick_cnt <= '0;
          end
        end
        RUN: begin
          // A pause on the tick cycle wins; the counter holds so the tick fires right after resume.
          if (btnPause) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            tick_cnt <= '0;
            if (cur_zero) begin
              state     <= ALARM;
              running   <= 1'b0;
              alarm     <= 1'b1;
              alarm_cnt <= '0;
            end else begin
              state        <= STEP;
              tmr.tmrStart <= 1'b1;
              step_cnt     <= '0;
              pause_pend   <= 1'b0;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STEP: begin
          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
          if (step_cnt == STEP_LAST) begin
            if (tmr.tmrComplete) cur <= merged;
            else                 stepErr <= 1'b1;
            if (pause_pend || btnPause) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else begin
              state <= RUN;
            end
            pause_pend <= 1'b0;
          end else begin
            step_cnt <= step_cnt + 1'b1;
            if (btnPause) pause_pend <= 1'b1;
          end
        end
        PAUSE: begin
          if (btnStart) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        ALARM: begin
          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
          if (btnStart || (tick && alarm_cnt == ALARM_LAST)) begin
            state <= IDLE;
            cur   <= '0;
            alarm <= 1'b0;
          end else if (tick) begin
            alarm_cnt <= alarm_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nap_controller.sv
// Scoreboard bench for nap_controller: stimulus queues the expected output changes with cycle gaps,
// a monitor compares every observed change of the visible outputs against the queue.
module tb_nap_controller;
  localparam int unsigned TPS   = 10;
  localparam int unsigned SWAIT = 3;
  localparam int unsigned ASEC  = 2;

  typedef struct packed {
    logic [23:0] disp;
    logic        running;
    logic        alarm;
    logic        load_err;
    logic        step_err;
    logic        tmr_start;
  } obs_t;

  localparam obs_t RESET_OBS = '0;

  logic clock = 1'b0;
  logic reset, load, btnStart, btnPause, btnCancel;
  logic [3:0] setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1;
  logic [3:0] dispHour10, dispHour1, dispMinute10, dispMinute1, dispSecond10, dispSecond1;
  logic running, alarm, loadErr, stepErr;

  nap_controller_if tmr_bus ();

  nap_controller #(
    .TICKS_PER_SEC(TPS),
    .STEP_WAIT    (SWAIT),
    .ALARM_SECONDS(ASEC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .setHour10   (setHour10),
    .setHour1    (setHour1),
    .setMinute10 (setMinute10),
    .setMinute1  (setMinute1),
    .setSecond10 (setSecond10),
    .setSecond1  (setSecond1),
    .btnStart    (btnStart),
    .btnPause    (btnPause),
    .btnCancel   (btnCancel),
    .tmr         (tmr_bus.master),
    .dispHour10  (dispHour10),
    .dispHour1   (dispHour1),
    .dispMinute10(dispMinute10),
    .dispMinute1 (dispMinute1),
    .dispSecond10(dispSecond10),
    .dispSecond1 (dispSecond1),
    .running     (running),
    .alarm       (alarm),
    .loadErr     (loadErr),
    .stepErr     (stepErr)
  );

  always #5 clock = ~clock;

  // Step datapath stand-in: a one-second BCD decrement, or a forced vector to probe the merge.
  logic        dp_override, dp_complete;
  logic [23:0] dp_value, set_word, get_word, disp_word;

  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  d, lim;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 1 || i == 3) ? 4'd5 : 4'd9;
      d   = r[i*4 +: 4];
      if (borrow) begin
        if (d == 4'd0) d = lim;
        else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  assign set_word = {tmr_bus.tmrSetHour10, tmr_bus.tmrSetHour1, tmr_bus.tmrSetMinute10,
                     tmr_bus.tmrSetMinute1, tmr_bus.tmrSetSecond10, tmr_bus.tmrSetSecond1};
  assign get_word = dp_override ? dp_value : bcd_dec(set_word);
  assign {tmr_bus.tmrGetHour10, tmr_bus.tmrGetHour1, tmr_bus.tmrGetMinute10,
          tmr_bus.tmrGetMinute1, tmr_bus.tmrGetSecond10, tmr_bus.tmrGetSecond1} = get_word;
  assign tmr_bus.tmrComplete = dp_complete;
  assign disp_word = {dispHour10, dispHour1, dispMinute10, dispMinute1, dispSecond10, dispSecond1};

  obs_t        exp_q[$];
  int          gap_q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned timeout_req = 0;
  int unsigned timeout_seen = 0;
  logic        mon_en = 1'b0;

  initial begin : monitor
    obs_t prev, obs, e;
    int   cyc, last, g;
    bit   started;
    prev    = RESET_OBS;
    cyc     = 0;
    last    = 0;
    started = 1'b0;
    forever begin
      @(negedge clock);
      if (timeout_req != timeout_seen) begin
        timeout_seen = timeout_req;
        total++;
        bad++;
        exp_q.delete();
        gap_q.delete();
      end
      if (mon_en) begin
        cyc++;
        obs = {disp_word, running, alarm, loadErr, stepErr, tmr_bus.tmrStart};
        if (!started) begin
          started = 1'b1;
          total++;
          if (obs !== RESET_OBS) begin
            bad++;
            $display("FAIL reset_state: got %h required %h", obs, RESET_OBS);
          end
          prev = obs;
          last = cyc;
        end else if (obs !== prev) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change: got disp=%h run=%b alm=%b lerr=%b serr=%b ts=%b required no change",
                     obs.disp, obs.running, obs.alarm, obs.load_err, obs.step_err, obs.tmr_start);
          end else begin
            e = exp_q.pop_front();
            g = gap_q.pop_front();
            if (obs !== e) begin
              bad++;
              $display("FAIL outputs: got disp=%h run=%b alm=%b lerr=%b serr=%b ts=%b required disp=%h run=%b alm=%b lerr=%b serr=%b ts=%b",
                       obs.disp, obs.running, obs.alarm, obs.load_err, obs.step_err, obs.tmr_start,
                       e.disp, e.running, e.alarm, e.load_err, e.step_err, e.tmr_start);
            end
            if (g != 0) begin
              total++;
              if ((cyc - last) != g) begin
                bad++;
                $display("FAIL gap: disp=%h got %0d cycles required %0d", obs.disp, cyc - last, g);
              end
            end
          end
          prev = obs;
          last = cyc;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_load(input logic [23:0] v);
    {setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1} = v;
    load = 1'b1;
    wait_cyc(1);
    load = 1'b0;
  endtask

  task automatic pulse_start;
    btnStart = 1'b1;
    wait_cyc(1);
    btnStart = 1'b0;
  endtask

  task automatic pulse_pause;
    btnPause = 1'b1;
    wait_cyc(1);
    btnPause = 1'b0;
  endtask

  task automatic pulse_cancel;
    btnCancel = 1'b1;
    wait_cyc(1);
    btnCancel = 1'b0;
  endtask

  // gap = cycles since the previous output change, 0 = not checked
  task automatic expect_obs(input logic [23:0] d, input logic r, input logic a, input logic le,
                            input logic se, input logic ts, input int g);
    obs_t o;
    o = {d, r, a, le, se, ts};
    exp_q.push_back(o);
    gap_q.push_back(g);
  endtask

  task automatic drain(input int limit, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      wait_cyc(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL %s: got %0d expected changes pending after %0d cycles required 0", tag, exp_q.size(), limit);
      timeout_req++;
    end
    wait_cyc(2);
  endtask

  task automatic cancel_to_idle(input string tag);
    expect_obs(24'h000000, 0, 0, 0, 0, 0, 0);
    pulse_cancel();
    drain(10, tag);
  endtask

  initial begin : stimulus
    logic [23:0] v;
    reset = 1'b1; load = 1'b0; btnStart = 1'b0; btnPause = 1'b0; btnCancel = 1'b0;
    {setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1} = '0;
    dp_override = 1'b0; dp_complete = 1'b1; dp_value = '0;
    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    wait_cyc(2);

    // Full countdown 3 s to alarm, then alarm auto-expiry after ASEC seconds.
    v = 24'h000003;
    expect_obs(v, 0, 0, 0, 0, 0, 0);
    expect_obs(v, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      expect_obs(v, 1, 0, 0, 0, 1, (k == 0) ? 10 : 6);
      expect_obs(v, 1, 0, 0, 0, 0, 1);
      v = v - 24'h1;
      expect_obs(v, 1, 0, 0, 0, 0, 3);
    end
    expect_obs(24'h000000, 0, 1, 0, 0, 0, 6);
    expect_obs(24'h000000, 0, 0, 0, 0, 0, 20);
    do_load(24'h000003);
    pulse_start();
    drain(120, "countdown");

    // Borrow through every digit.
    expect_obs(24'h100000, 0, 0, 0, 0, 0, 0);
    expect_obs(24'h100000, 1, 0, 0, 0, 0, 0);
    expect_obs(24'h100000, 1, 0, 0, 0, 1, 10);
    expect_obs(24'h100000, 1, 0, 0, 0, 0, 1);
    expect_obs(24'h095959, 1, 0, 0, 0, 0, 3);
    do_load(24'h100000);
    pulse_start();
    drain(40, "borrow_all");
    cancel_to_idle("cancel_borrow_all");

    // Digits above the borrow position keep cur even when the datapath returns junk there.
    dp_value    = 24'h991959;
    dp_override = 1'b1;
    expect_obs(24'h012000, 0, 0, 0, 0, 0, 0);
    expect_obs(24'h012000, 1, 0, 0, 0, 0, 0);
    expect_obs(24'h012000, 1, 0, 0, 0, 1, 10);
    expect_obs(24'h012000, 1, 0, 0, 0, 0, 1);
    expect_obs(24'h011959, 1, 0, 0, 0, 0, 3);
    do_load(24'h012000);
    pulse_start();
    drain(40, "borrow_keep_hours");
    cancel_to_idle("cancel_keep_hours");
    dp_override = 1'b0;

    // Invalid load pulses loadErr only.
    expect_obs(24'h000000, 0, 0, 1, 0, 0, 0);
    expect_obs(24'h000000, 0, 0, 0, 0, 0, 1);
    do_load(24'h006100);
    drain(10, "invalid_load");

    // Load during RUN is ignored.
    expect_obs(24'h000005, 0, 0, 0, 0, 0, 0);
    expect_obs(24'h000005, 1, 0, 0, 0, 0, 0);
    expect_obs(24'h000005, 1, 0, 0, 0, 1, 10);
    expect_obs(24'h000005, 1, 0, 0, 0, 0, 1);
    expect_obs(24'h000004, 1, 0, 0, 0, 0, 3);
    do_load(24'h000005);
    pulse_start();
    wait_cyc(3);
    do_load(24'h000007);
    drain(40, "load_in_run");
    cancel_to_idle("cancel_load_in_run");

    // Pause at count 7 for 25 cycles, then pause on the tick cycle itself.
    expect_obs(24'h000005, 0, 0, 0, 0, 0, 0);
    expect_obs(24'h000005, 1, 0, 0, 0, 0, 0);
    expect_obs(24'h000005, 0, 0, 0, 0, 0, 8);
    expect_obs(24'h000005, 1, 0, 0, 0, 0, 25);
    expect_obs(24'h000005, 1, 0, 0, 0, 1, 3);
    expect_obs(24'h000005, 1, 0, 0, 0, 0, 1);
    expect_obs(24'h000004, 1, 0, 0, 0, 0, 3);
    expect_obs(24'h000004, 0, 0, 0, 0, 0, 6);
    expect_obs(24'h000004, 1, 0, 0, 0, 0, 10);
    expect_obs(24'h000004, 1, 0, 0, 0, 1, 1);
    expect_obs(24'h000004, 1, 0, 0, 0, 0, 1);
    expect_obs(24'h000003, 1, 0, 0, 0, 0, 3);
    do_load(24'h000005);
    pulse_start();
    wait_cyc(7);
    pulse_pause();
    wait_cyc(24);
    pulse_start();
    wait_cyc(12);
    pulse_pause();
    wait_cyc(9);
    pulse_start();
    drain(40, "pause_resume");
    cancel_to_idle("cancel_pause");

    // Pause during STEP is deferred to the capture.
    expect_obs(24'h000005, 0, 0, 0, 0, 0, 0);
    expect_obs(24'h000005, 1, 0, 0, 0, 0, 0);
    expect_obs(24'h000005, 1, 0, 0, 0, 1, 10);
    expect_obs(24'h000005, 1, 0, 0, 0, 0, 1);
    expect_obs(24'h000004, 0, 0, 0, 0, 0, 3);
    do_load(24'h000005);
    pulse_start();
    wait_cyc(11);
    pulse_pause();
    drain(40, "pause_in_step");
    cancel_to_idle("cancel_pause_in_step");

    // Datapath not complete at capture: stepErr, value kept; cancel clears it.
    dp_complete = 1'b0;
    expect_obs(24'h000005, 0, 0, 0, 0, 0, 0);
    expect_obs(24'h000005, 1, 0, 0, 0, 0, 0);
    expect_obs(24'h000005, 1, 0, 0, 0, 1, 10);
    expect_obs(24'h000005, 1, 0, 0, 0, 0, 1);
    expect_obs(24'h000005, 1, 0, 0, 1, 0, 3);
    do_load(24'h000005);
    pulse_start();
    drain(40, "step_error");
    dp_complete = 1'b1;
    cancel_to_idle("cancel_step_error");

    // Alarm silenced by start.
    expect_obs(24'h000001, 0, 0, 0, 0, 0, 0);
    expect_obs(24'h000001, 1, 0, 0, 0, 0, 0);
    expect_obs(24'h000001, 1, 0, 0, 0, 1, 10);
    expect_obs(24'h000001, 1, 0, 0, 0, 0, 1);
    expect_obs(24'h000000, 1, 0, 0, 0, 0, 3);
    expect_obs(24'h000000, 0, 1, 0, 0, 0, 6);
    do_load(24'h000001);
    pulse_start();
    drain(40, "alarm_on");
    expect_obs(24'h000000, 0, 0, 0, 0, 0, 0);
    pulse_start();
    drain(10, "alarm_silence");

    // Reset right after the step strobe; a late completion must not revive anything.
    dp_complete = 1'b0;
    expect_obs(24'h000005, 0, 0, 0, 0, 0, 0);
    expect_obs(24'h000005, 1, 0, 0, 0, 0, 0);
    expect_obs(24'h000005, 1, 0, 0, 0, 1, 10);
    expect_obs(24'h000000, 0, 0, 0, 0, 0, 1);
    do_load(24'h000005);
    pulse_start();
    wait_cyc(10);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    dp_complete = 1'b1;
    drain(10, "reset_mid_step");
    wait_cyc(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
